// File: rtl/victim_cache_controller.sv
// Sequencer for a small fully-associative victim cache. It keeps the tag/valid/dirty
// array and the replacement pointer, and it steers an external victim data array.
module victim_cache_controller #(
  parameter int VC_ENTRIES  = 4,
  parameter int LINE_ADDR_W = 28,
  localparam int WAY_W      = $clog2(VC_ENTRIES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   lookup_req_i,
  input  logic [LINE_ADDR_W-1:0] lookup_addr_i,
  input  logic                   evict_valid_i,
  input  logic                   evict_dirty_i,
  input  logic [LINE_ADDR_W-1:0] evict_addr_i,
  input  logic                   kill_i,
  input  logic                   flush_i,
  output logic                   lookup_done_o,
  output logic                   victim_hit_o,
  output logic                   victim_dirty_o,
  output logic                   swap_to_dcache_o,
  output logic                   vc_rd_o,
  output logic                   vc_wr_o,
  output logic [WAY_W-1:0]       vc_way_o,
  output logic                   wb_req_o,
  output logic [LINE_ADDR_W-1:0] wb_addr_o,
  input  logic                   wb_ack_i,
  output logic                   flush_done_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOOKUP, S_SWAP, S_WRITEBACK, S_INSERT, S_DONE,
    S_FLUSH_SCAN, S_FLUSH_WB, S_FLUSH_DONE
  } state_t;

  localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(VC_ENTRIES - 1);
  localparam logic [WAY_W-1:0] ONE_WAY  = WAY_W'(1);

  state_t                   r_state;
  state_t                   w_next_raw;
  state_t                   w_next;
  logic [VC_ENTRIES-1:0]    r_valid;
  logic [VC_ENTRIES-1:0]    r_dirty;
  logic [LINE_ADDR_W-1:0]   r_tag [VC_ENTRIES];
  logic [WAY_W-1:0]         r_rr_ptr;
  logic [WAY_W-1:0]         r_way;
  logic [LINE_ADDR_W-1:0]   r_addr;
  logic                     r_ev_valid;
  logic                     r_ev_dirty;
  logic [LINE_ADDR_W-1:0]   r_ev_addr;
  logic                     r_from_rr;
  logic                     r_hit;
  logic                     r_vdirty;

  logic                     w_hit;
  logic [WAY_W-1:0]         w_hit_way;
  logic                     w_free;
  logic [WAY_W-1:0]         w_free_way;
  logic [WAY_W-1:0]         w_tgt_way;
  logic                     w_tgt_wb;
  logic                     w_done;
  logic                     w_swap;
  logic                     w_rd;
  logic                     w_wr;
  logic [WAY_W-1:0]         w_way;
  logic                     w_wb_req;
  logic [LINE_ADDR_W-1:0]   w_wb_addr;
  logic                     w_fdone;
  logic                     w_scan_wb;

  // Associative match and lowest free entry; scanning downward leaves the lowest index.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_way  = {WAY_W{1'b0}};
    w_free     = 1'b0;
    w_free_way = {WAY_W{1'b0}};
    for (int i = VC_ENTRIES - 1; i >= 0; i--) begin
      w_hit      = (r_valid[i] && (r_tag[i] == r_addr)) ? 1'b1 : w_hit;
      w_hit_way  = (r_valid[i] && (r_tag[i] == r_addr)) ? WAY_W'(i) : w_hit_way;
      w_free     = (!r_valid[i]) ? 1'b1 : w_free;
      w_free_way = (!r_valid[i]) ? WAY_W'(i) : w_free_way;
    end
    w_tgt_way = w_free ? w_free_way : r_rr_ptr;
    w_tgt_wb  = r_valid[w_tgt_way] && r_dirty[w_tgt_way];
    w_scan_wb = r_valid[r_way] && r_dirty[r_way];
  end

  // Next state and raw (pre-kill) output decode.
  always_comb begin
    w_next_raw = r_state;
    w_done     = 1'b0;
    w_swap     = 1'b0;
    w_rd       = 1'b0;
    w_wr       = 1'b0;
    w_way      = r_way;
    w_wb_req   = 1'b0;
    w_wb_addr  = r_tag[r_way];
    w_fdone    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (flush_i) begin
          w_next_raw = S_FLUSH_SCAN;
        end else if (lookup_req_i) begin
          w_next_raw = S_LOOKUP;
        end else begin
          w_next_raw = S_IDLE;
        end
      end
      S_LOOKUP: begin
        if (w_hit) begin
          w_rd       = 1'b1;
          w_way      = w_hit_way;
          w_next_raw = S_SWAP;
        end else if (!evict_valid_i) begin
          w_next_raw = S_DONE;
        end else if (w_tgt_wb) begin
          w_rd       = 1'b1;
          w_wb_req   = 1'b1;
          w_way      = w_tgt_way;
          w_wb_addr  = r_tag[w_tgt_way];
          w_next_raw = S_WRITEBACK;
        end else begin
          w_next_raw = S_INSERT;
        end
      end
      S_SWAP: begin
        w_swap     = 1'b1;
        w_wr       = r_ev_valid;
        w_next_raw = S_DONE;
      end
      S_WRITEBACK: begin
        w_wb_req   = 1'b1;
        w_next_raw = wb_ack_i ? S_INSERT : S_WRITEBACK;
      end
      S_INSERT: begin
        w_wr       = 1'b1;
        w_next_raw = S_DONE;
      end
      S_DONE: begin
        w_done     = 1'b1;
        w_next_raw = S_IDLE;
      end
      S_FLUSH_SCAN: begin
        if (w_scan_wb) begin
          w_rd       = 1'b1;
          w_wb_req   = 1'b1;
          w_next_raw = S_FLUSH_WB;
        end else if (r_way == LAST_WAY) begin
          w_next_raw = S_FLUSH_DONE;
        end else begin
          w_next_raw = S_FLUSH_SCAN;
        end
      end
      S_FLUSH_WB: begin
        w_wb_req = 1'b1;
        if (wb_ack_i) begin
          w_next_raw = (r_way == LAST_WAY) ? S_FLUSH_DONE : S_FLUSH_SCAN;
        end else begin
          w_next_raw = S_FLUSH_WB;
        end
      end
      S_FLUSH_DONE: begin
        w_fdone    = 1'b1;
        w_next_raw = S_IDLE;
      end
      default: begin
        w_next_raw = S_IDLE;
      end
    endcase
  end

  // kill_i suppresses every side-effecting strobe in its cycle; the read is harmless.
  assign w_next           = kill_i ? S_IDLE : w_next_raw;
  assign lookup_done_o    = w_done & ~kill_i;
  assign victim_hit_o     = w_done & r_hit;
  assign victim_dirty_o   = w_done & r_vdirty;
  assign swap_to_dcache_o = w_swap & ~kill_i;
  assign vc_rd_o          = w_rd;
  assign vc_wr_o          = w_wr & ~kill_i;
  assign vc_way_o         = (w_rd | w_wr | w_swap | w_wb_req) ? w_way : {WAY_W{1'b0}};
  assign wb_req_o         = w_wb_req & ~kill_i;
  assign wb_addr_o        = (w_wb_req & ~kill_i) ? w_wb_addr : {LINE_ADDR_W{1'b0}};
  assign flush_done_o     = w_fdone & ~kill_i;

  // State register plus entry array, pointer and per-operation latches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_valid    <= {VC_ENTRIES{1'b0}};
      r_dirty    <= {VC_ENTRIES{1'b0}};
      for (int i = 0; i < VC_ENTRIES; i++) begin
        r_tag[i] <= {LINE_ADDR_W{1'b0}};
      end
      r_rr_ptr   <= {WAY_W{1'b0}};
      r_way      <= {WAY_W{1'b0}};
      r_addr     <= {LINE_ADDR_W{1'b0}};
      r_ev_valid <= 1'b0;
      r_ev_dirty <= 1'b0;
      r_ev_addr  <= {LINE_ADDR_W{1'b0}};
      r_from_rr  <= 1'b0;
      r_hit      <= 1'b0;
      r_vdirty   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (!kill_i) begin
        case (r_state)
          S_IDLE: begin
            if (flush_i) begin
              r_way <= {WAY_W{1'b0}};
            end else if (lookup_req_i) begin
              r_addr <= lookup_addr_i;
            end
          end
          S_LOOKUP: begin
            r_ev_valid <= evict_valid_i;
            r_ev_dirty <= evict_dirty_i;
            r_ev_addr  <= evict_addr_i;
            r_hit      <= w_hit;
            r_vdirty   <= 1'b0;
            r_way      <= w_hit ? w_hit_way : w_tgt_way;
            r_from_rr  <= ~w_free;
          end
          S_SWAP: begin
            r_vdirty       <= r_dirty[r_way];
            r_valid[r_way] <= r_ev_valid;
            r_dirty[r_way] <= r_ev_valid & r_ev_dirty;
            if (r_ev_valid) begin
              r_tag[r_way] <= r_ev_addr;
            end
          end
          S_WRITEBACK: begin
            if (wb_ack_i) begin
              r_dirty[r_way] <= 1'b0;
            end
          end
          S_INSERT: begin
            r_valid[r_way] <= 1'b1;
            r_dirty[r_way] <= r_ev_dirty;
            r_tag[r_way]   <= r_ev_addr;
            if (r_from_rr) begin
              r_rr_ptr <= r_rr_ptr + ONE_WAY;
            end
          end
          S_FLUSH_SCAN: begin
            if (!w_scan_wb) begin
              r_valid[r_way] <= 1'b0;
              r_dirty[r_way] <= 1'b0;
              if (r_way != LAST_WAY) begin
                r_way <= r_way + ONE_WAY;
              end
            end
          end
          S_FLUSH_WB: begin
            if (wb_ack_i) begin
              r_valid[r_way] <= 1'b0;
              r_dirty[r_way] <= 1'b0;
              if (r_way != LAST_WAY) begin
                r_way <= r_way + ONE_WAY;
              end
            end
          end
          S_FLUSH_DONE: begin
            r_rr_ptr <= {WAY_W{1'b0}};
          end
          default: begin
            r_way <= r_way;
          end
        endcase
      end
    end
  end

endmodule
